// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant, one
// operation in flight, registered results returned as a one-cycle pulse.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [3:0]  req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [3:0]  req1_cmd,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp_hi,
  output logic [15:0] rsp_lo,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_cmd,
  input  logic [15:0] alu_hi,
  input  logic [15:0] alu_lo,
  output logic        busy
);

  localparam int unsigned W     = 16;
  localparam int unsigned CW    = 4;
  localparam int unsigned CNT_W = 3;
  localparam logic [CW-1:0] CMD_FIRST = CW'(1);
  localparam logic [CW-1:0] CMD_MUL   = CW'(9);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [CW-1:0]    cmd_q, cmd_d;
  logic             gid_q, gid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic [W-1:0]     rsp_hi_q, rsp_hi_d;
  logic [W-1:0]     rsp_lo_q, rsp_lo_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic grant0, grant1, cmd_legal, drive_alu;

  // rr_q low: req0 wins a tie; a lone valid requester always wins
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~rr_q);
    grant1 = req1_valid & (~req0_valid | rr_q);
  end

  always_comb begin
    cmd_legal = (cmd_q >= CMD_FIRST) && (cmd_q <= CMD_MUL);
    drive_alu = ((state_q == EXEC) || (state_q == WAIT)) && cmd_legal;
  end

  // Next-state and capture logic
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cmd_d      = cmd_q;
    gid_d      = gid_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    rsp_hi_d   = rsp_hi_q;
    rsp_lo_d   = rsp_lo_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          a_d     = grant1 ? req1_a   : req0_a;
          b_d     = grant1 ? req1_b   : req0_b;
          cmd_d   = grant1 ? req1_cmd : req0_cmd;
          gid_d   = grant1;
          rr_d    = grant0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!cmd_legal) begin
          rsp_hi_d   = '0;
          rsp_lo_d   = '0;
          rsp_zero_d = 1'b1;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else if (cmd_q == CMD_MUL) begin
          cnt_d   = CNT_W'(MUL_CYCLES);
          state_d = WAIT;
        end else begin
          // upper ALU word is stale for anything but a multiply
          rsp_hi_d   = '0;
          rsp_lo_d   = alu_lo;
          rsp_zero_d = (alu_lo == '0);
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_hi_d   = alu_hi;
          rsp_lo_d   = alu_lo;
          rsp_zero_d = (alu_hi == '0) && (alu_lo == '0);
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cmd_q      <= '0;
      gid_q      <= 1'b0;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      rsp_hi_q   <= '0;
      rsp_lo_q   <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cmd_q      <= cmd_d;
      gid_q      <= gid_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      rsp_hi_q   <= rsp_hi_d;
      rsp_lo_q   <= rsp_lo_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Ready is masked by reset so nothing appears accepted while held in reset
  always_comb begin
    req0_ready = rst_n & (state_q == IDLE) & grant0;
    req1_ready = rst_n & (state_q == IDLE) & grant1;
    rsp0_valid = (state_q == RESP) & ~gid_q;
    rsp1_valid = (state_q == RESP) & gid_q;
    busy       = (state_q != IDLE);
    alu_a      = drive_alu ? a_q   : '0;
    alu_b      = drive_alu ? b_q   : '0;
    alu_cmd    = drive_alu ? cmd_q : '0;
    rsp_hi     = rsp_hi_q;
    rsp_lo     = rsp_lo_q;
    rsp_zero   = rsp_zero_q;
    rsp_err    = rsp_err_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: environment ALU, transaction-level reference model
// compared every cycle, directed literal scenarios, then random traffic.
module tb_alu_arbiter;

  localparam int unsigned MUL = 1;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_cmd, req1_cmd;
  logic        rsp0_valid, rsp1_valid, rsp_zero, rsp_err, busy;
  logic [15:0] rsp_hi, rsp_lo, alu_a, alu_b, alu_hi, alu_lo;
  logic [3:0]  alu_cmd;

  alu_arbiter #(.MUL_CYCLES(MUL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_hi(alu_hi), .alu_lo(alu_lo), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    case (c)
      4'd1: alu_fn = {16'h0, 16'(a + b)};
      4'd2: alu_fn = {16'h0, 16'(a - b)};
      4'd3: alu_fn = {16'h0, a & b};
      4'd4: alu_fn = {16'h0, a | b};
      4'd5: alu_fn = {16'h0, a ^ b};
      4'd6: alu_fn = {16'h0, 16'(a << b[3:0])};
      4'd7: alu_fn = {16'h0, 16'($signed(a) >>> b[3:0])};
      4'd8: alu_fn = {16'h0, 16'(a >> b[3:0])};
      4'd9: alu_fn = 32'(a) * 32'(b);
      default: alu_fn = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Environment ALU: garbage on the words the arbiter must not trust
  logic [15:0] stale_hi, stale_lo;
  logic [31:0] alu_r;
  always @(posedge clk) begin
    stale_hi <= 16'($urandom);
    stale_lo <= 16'($urandom);
  end
  always_comb begin
    alu_r  = alu_fn(alu_cmd, alu_a, alu_b);
    alu_lo = (alu_cmd >= 4'd1 && alu_cmd <= 4'd9) ? alu_r[15:0] : stale_lo;
    alu_hi = (alu_cmd == 4'd9) ? alu_r[31:16] : stale_hi;
  end

  // Reference model: one pending transaction with known accept/response cycles
  bit          m_pend, m_id, m_rr, m_zero, m_err, p_zero, p_err;
  int          m_acc, m_resp;
  logic [3:0]  m_cmd;
  logic [15:0] m_a, m_b, m_hi, m_lo, p_hi, p_lo;
  bit          acc0, acc1, g0, g1, e_r0, e_r1, legal;
  logic [15:0] ea, eb;
  logic [3:0]  ec;
  logic [31:0] fr;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend = 0; m_rr = 0; m_hi = '0; m_lo = '0; m_zero = 0; m_err = 0;
      acc0 = 0; acc1 = 0;
      chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_data", {rsp_hi, rsp_lo}, 32'd0);
      chk("rst_rsp_flags", 32'({rsp_zero, rsp_err}), 32'd0);
      chk("rst_alu", {alu_a, alu_b}, 32'd0);
      chk("rst_alu_cmd", 32'(alu_cmd), 32'd0);
    end else begin
      e_r0 = m_pend && (cyc == m_resp) && !m_id;
      e_r1 = m_pend && (cyc == m_resp) && m_id;
      if (m_pend && cyc == m_resp) begin
        m_hi = p_hi; m_lo = p_lo; m_zero = p_zero; m_err = p_err;
      end
      legal = (m_cmd >= 4'd1) && (m_cmd <= 4'd9);
      if (m_pend && cyc > m_acc && cyc < m_resp && legal) begin
        ea = m_a; eb = m_b; ec = m_cmd;
      end else begin
        ea = '0; eb = '0; ec = '0;
      end
      g0 = !m_pend && req0_valid && (!req1_valid || !m_rr);
      g1 = !m_pend && req1_valid && (!req0_valid || m_rr);
      chk("ready", 32'({req0_ready, req1_ready}), 32'({g0, g1}));
      chk("rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'({e_r0, e_r1}));
      chk("busy", 32'(busy), 32'(m_pend));
      chk("rsp_data", {rsp_hi, rsp_lo}, {m_hi, m_lo});
      chk("rsp_flags", 32'({rsp_zero, rsp_err}), 32'({m_zero, m_err}));
      chk("alu_ops", {alu_a, alu_b}, {ea, eb});
      chk("alu_cmd", 32'(alu_cmd), 32'(ec));
      if (m_pend && cyc == m_resp) m_pend = 0;
      acc0 = g0;
      acc1 = g1;
      if (g0 || g1) begin
        m_pend = 1;
        m_id   = g1;
        m_cmd  = g1 ? req1_cmd : req0_cmd;
        m_a    = g1 ? req1_a : req0_a;
        m_b    = g1 ? req1_b : req0_b;
        m_rr   = g0;
        m_acc  = cyc;
        m_resp = cyc + 2 + ((m_cmd == 4'd9) ? int'(MUL) : 0);
        fr = alu_fn(m_cmd, m_a, m_b);
        if (m_cmd >= 4'd1 && m_cmd <= 4'd9) begin
          p_hi  = (m_cmd == 4'd9) ? fr[31:16] : 16'h0;
          p_lo  = fr[15:0];
          p_err = 0;
        end else begin
          p_hi = '0; p_lo = '0; p_err = 1;
        end
        p_zero = (p_hi == 16'h0) && (p_lo == 16'h0);
      end
    end
  end

  task automatic drive(input int id, input bit v, input logic [3:0] c,
                       input logic [15:0] a, input logic [15:0] b);
    if (id == 0) begin
      req0_valid = v; req0_cmd = c; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_cmd = c; req1_a = a; req1_b = b;
    end
  endtask

  task automatic await_ready(input int id, output int at);
    at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        at = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL await_ready%0d: got timeout expected ready within 20 cycles", id);
  endtask

  task automatic await_rsp(input int id, output int at);
    at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((id == 0) ? rsp0_valid : rsp1_valid) begin
        at = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL await_rsp%0d: got timeout expected rsp within 20 cycles", id);
  endtask

  task automatic rand_req(input int id);
    bit v, acc;
    acc = (id == 0) ? acc0 : acc1;
    v   = (id == 0) ? req0_valid : req1_valid;
    if (acc || (v && $urandom_range(0, 15) == 0)) v = 0;
    if (!v && $urandom_range(0, 1) == 1) begin
      logic [3:0] c;
      logic [15:0] a, b;
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9));
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      drive(id, 1'b1, c, a, b);
    end else if (!v) begin
      if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
  endtask

  int t, r;

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b1, 4'd2, 16'h0005, 16'h0005);
    drive(1, 1'b1, 4'd4, 16'h00F0, 16'h000F);

    // Reset with both requesters waiting, then round-robin from reset
    repeat (3) @(negedge clk);
    chk("lit_reset_busy", 32'(busy), 32'd0);
    chk("lit_reset_ready0", 32'(req0_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_first_grant", 32'({req0_ready, req1_ready}), 32'b10);
    t = cyc;
    @(posedge clk); #1 drive(0, 1'b0, 4'd0, 16'h0, 16'h0);
    await_rsp(0, r);
    chk("lit_sub_latency", 32'(r - t), 32'd2);
    chk("lit_sub_zero", 32'({rsp_zero, rsp_lo}), 32'h10000);
    await_ready(1, t);
    @(posedge clk); #1 drive(1, 1'b0, 4'd0, 16'h0, 16'h0);
    await_rsp(1, r);
    chk("lit_or_latency", 32'(r - t), 32'd2);
    chk("lit_or_result", {rsp_hi, rsp_lo}, 32'h0000_00FF);
    @(posedge clk); #1;
    drive(0, 1'b1, 4'd1, 16'h0001, 16'h0001);
    drive(1, 1'b1, 4'd1, 16'h0002, 16'h0002);
    @(negedge clk);
    chk("lit_rr_again", 32'({req0_ready, req1_ready}), 32'b10);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd0, 16'h0, 16'h0);
    drive(1, 1'b0, 4'd0, 16'h0, 16'h0);
    await_rsp(0, r);

    // Lone add
    @(posedge clk); #1 drive(0, 1'b1, 4'd1, 16'h0003, 16'h0004);
    await_ready(0, t);
    @(posedge clk); #1 drive(0, 1'b0, 4'd0, 16'h0, 16'h0);
    await_rsp(0, r);
    chk("lit_add_latency", 32'(r - t), 32'd2);
    chk("lit_add_result", {rsp_hi, rsp_lo}, 32'h0000_0007);
    chk("lit_add_flags", 32'({rsp_zero, rsp1_valid}), 32'd0);

    // Multiply
    @(posedge clk); #1 drive(1, 1'b1, 4'd9, 16'h0100, 16'h0100);
    await_ready(1, t);
    @(posedge clk); #1 drive(1, 1'b0, 4'd0, 16'h0, 16'h0);
    await_rsp(1, r);
    chk("lit_mul_latency", 32'(r - t), 32'(2 + MUL));
    chk("lit_mul_result", {rsp_hi, rsp_lo}, 32'h0001_0000);
    chk("lit_mul_zero", 32'(rsp_zero), 32'd0);

    // Illegal command
    @(posedge clk); #1 drive(0, 1'b1, 4'd12, 16'h1234, 16'h5678);
    await_ready(0, t);
    @(posedge clk); #1 drive(0, 1'b0, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    chk("lit_illegal_alu_cmd", 32'(alu_cmd), 32'd0);
    await_rsp(0, r);
    chk("lit_illegal_latency", 32'(r - t), 32'd2);
    chk("lit_illegal_result", {rsp_hi, rsp_lo}, 32'd0);
    chk("lit_illegal_flags", 32'({rsp_zero, rsp_err}), 32'b11);

    // Reset during the multiply wait
    @(posedge clk); #1 drive(1, 1'b1, 4'd9, 16'h00FF, 16'h0101);
    await_ready(1, t);
    @(posedge clk); #1 drive(1, 1'b0, 4'd0, 16'h0, 16'h0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("lit_midreset_busy", 32'(busy), 32'd0);
    chk("lit_midreset_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lit_no_stale_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    end
    @(posedge clk); #1 drive(0, 1'b1, 4'd5, 16'hFF00, 16'h0FF0);
    await_ready(0, t);
    @(posedge clk); #1 drive(0, 1'b0, 4'd0, 16'h0, 16'h0);
    await_rsp(0, r);
    chk("lit_post_reset_latency", 32'(r - t), 32'd2);
    chk("lit_post_reset_xor", {rsp_hi, rsp_lo}, 32'h0000_F0F0);

    // Random traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rand_req(0);
      rand_req(1);
    end
    drive(0, 1'b0, 4'd0, 16'h0, 16'h0);
    drive(1, 1'b0, 4'd0, 16'h0, 16'h0);
    repeat (12) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MUL_CYCLES, default 1, number of extra WAIT cycles granted to a multiply (cmd 9) before capture; legal range 1..7.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester N operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  16  operands of requester N.
REQ-007 req0_cmd / req1_cmd  input  4  ALU command of requester N (1 add, 2 sub, 3 and, 4 or, 5 xor, 6 sl, 7 sr, 8 sru, 9 mul).
REQ-008 rsp0_valid / rsp1_valid  output  1  one-cycle result pulse to requester N.
REQ-009 rsp_hi, rsp_lo  output  16  result upper/lower word, shared by both requesters.
REQ-010 rsp_zero  output  1  high when rsp_hi and rsp_lo are both 0.
REQ-011 rsp_err  output  1  high with rsp valid when the command was illegal.
REQ-012 alu_a, alu_b  output  16  operands driven to the shared ALU.
REQ-013 alu_cmd  output  4  command driven to the shared ALU.
REQ-014 alu_hi, alu_lo  input  16  ALU upper (multiply only) and lower result words.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, EXEC, WAIT, RESP; one ALU operation in flight at a time.
REQ-017 IDLE: grant = highest-priority valid requester; reqN_ready = (state==IDLE) & grantN, combinational; no valid -> both ready low.
REQ-018 Priority round-robin: after a grant to N, the other requester wins the next tie; after reset req0 wins the first tie; a lone valid requester is always granted.
REQ-019 Accept (valid & ready): latch a, b, cmd, grant id into operand registers; IDLE -> EXEC.
REQ-020 alu_a/alu_b/alu_cmd driven from operand registers only in EXEC and WAIT; alu_cmd = 0 (no-op) in IDLE and RESP so the ALU holds.
REQ-021 EXEC, cmd 1..8: capture rsp_lo = alu_lo, rsp_hi = 0 (ALU upper word is stale for non-multiply); -> RESP.
REQ-022 EXEC, cmd 9: load counter with MUL_CYCLES; -> WAIT.
REQ-023 WAIT: counter decrements each cycle; on the cycle it reads 1, capture rsp_hi = alu_hi, rsp_lo = alu_lo; -> RESP.
REQ-024 Illegal cmd (0, 10..15): ALU not driven (alu_cmd stays 0); EXEC captures rsp_hi = rsp_lo = 0, rsp_err = 1; -> RESP.
REQ-025 rsp_zero computed internally from captured rsp_hi/rsp_lo; no ALU zero flag used.
REQ-026 RESP: rspN_valid = 1 for the granted requester only, exactly one cycle, no back-pressure; -> IDLE.
REQ-027 Latency from accept edge T: non-multiply/illegal rsp valid in cycle T+2; multiply in T+2+MUL_CYCLES.
REQ-028 rsp_hi/rsp_lo/rsp_zero/rsp_err hold their values until the next capture.
REQ-029 Requests arriving in EXEC/WAIT/RESP see ready low and are not lost by the block; a requester dropping valid before acceptance has no effect.
REQ-030 Maximum throughput: one non-multiply operation every 3 cycles.

Reset
REQ-031 rst_n low forces IDLE immediately; all outputs 0, operand/result registers 0, counter 0, round-robin pointer to req0-first.
REQ-032 Reset mid-operation discards the operation; no rsp pulse is issued for it after reset releases.

Verification
REQ-033 Reset: assert rst_n low with req0_valid high -> all outputs 0, busy 0; release -> req0_ready 1 in that IDLE cycle.
REQ-034 req0 add a=0x0003 b=0x0004 accepted at T -> rsp0_valid in T+2, rsp_lo 0x0007, rsp_hi 0x0000, rsp_zero 0, rsp1_valid 0.
REQ-035 Both valid from reset: req0 sub 0x0005-0x0005, req1 or 0x00F0|0x000F held -> req0 served first (rsp_zero 1), req1 next (rsp_lo 0x00FF); both valid again -> req0 granted.
REQ-036 req1 mul 0x0100*0x0100, MUL_CYCLES 1 -> rsp1_valid in T+3, rsp_hi 0x0001, rsp_lo 0x0000, rsp_zero 0.
REQ-037 req0 cmd 12 -> rsp0_valid in T+2, rsp_err 1, rsp_hi/lo 0, rsp_zero 1, alu_cmd 0 throughout.
REQ-038 rst_n pulsed low during WAIT of a multiply -> busy 0 at once, no rsp pulse afterward, next request accepted normally.
